// File: rtl/spi_ram_master_if.sv
// Host command/response handshake plus the SPI pins of the serial RAM link.
// master modport: the SPI master block; slave modport: host and RAM-slave side.
// Carries no logic; all timing lives in spi_ram_master.
interface spi_ram_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_payload;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;

  modport master (
    input  cmd_valid, cmd_op, cmd_payload, MISO,
    output cmd_ready, rsp_valid, rsp_data, busy, MOSI, SS_n
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_payload, MISO,
    input  cmd_ready, rsp_valid, rsp_data, busy, MOSI, SS_n
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master for the serial RAM: sends {op, payload} as a 10-bit MSB-first frame, SCK = clk.
// Latency: read-data accept cycle to rsp_valid is LEAD_CYCLES+10+RD_GAP+8+1 cycles; other ops give no response.
// Backpressure: cmd_ready is high only in IDLE; a command offered while busy waits for the next IDLE cycle.
module spi_ram_master #(
  parameter int unsigned LEAD_CYCLES = 1,
  parameter int unsigned RD_GAP      = 1
) (
  input logic              clk,
  input logic              rst_n,
  spi_ram_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, LEAD, TX, GAP, RX, DONE} state_t;

  // Last count value of each timed phase; the counter restarts at 0 on every phase entry.
  localparam logic [3:0] LEAD_LAST = 4'(LEAD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = (RD_GAP == 0) ? 4'd0 : 4'(RD_GAP - 1);
  localparam logic [3:0] TX_LAST   = 4'd9;
  localparam logic [3:0] RX_LAST   = 4'd7;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [9:0] tx_sh, tx_sh_nx;   // tx_sh[9] is always the next bit to put on MOSI
  logic [6:0] rx_sh, rx_sh_nx;   // first seven MISO bits; the eighth joins them on the last RX edge
  logic       is_rd, is_rd_nx;
  logic       mosi_q, mosi_nx;
  logic       ss_q, ss_nx;
  logic       rsp_valid_q, rsp_valid_nx;
  logic [7:0] rsp_data_q, rsp_data_nx;

  // State and datapath registers; reset aborts any frame and clears the response byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      tx_sh       <= 10'd0;
      rx_sh       <= 7'd0;
      is_rd       <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      tx_sh       <= tx_sh_nx;
      rx_sh       <= rx_sh_nx;
      is_rd       <= is_rd_nx;
      mosi_q      <= mosi_nx;
      ss_q        <= ss_nx;
      rsp_valid_q <= rsp_valid_nx;
      rsp_data_q  <= rsp_data_nx;
    end
  end

  // Next-state and next-output logic; MOSI/SS_n are computed one cycle ahead so the pins stay registered.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    tx_sh_nx     = tx_sh;
    rx_sh_nx     = rx_sh;
    is_rd_nx     = is_rd;
    mosi_nx      = mosi_q;
    ss_nx        = ss_q;
    rsp_valid_nx = 1'b0;
    rsp_data_nx  = rsp_data_q;

    case (state)
      IDLE: begin
        ss_nx   = 1'b1;
        mosi_nx = 1'b0;
        if (bus.cmd_valid) begin
          tx_sh_nx = {bus.cmd_op, bus.cmd_payload};
          is_rd_nx = (bus.cmd_op == 2'b11);
          ss_nx    = 1'b0;
          cnt_nx   = 4'd0;
          state_nx = LEAD;
        end
      end

      LEAD: begin
        if (cnt == LEAD_LAST) begin
          mosi_nx  = tx_sh[9];
          tx_sh_nx = {tx_sh[8:0], 1'b0};
          cnt_nx   = 4'd0;
          state_nx = TX;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end

      TX: begin
        if (cnt == TX_LAST) begin
          mosi_nx = 1'b0;
          cnt_nx  = 4'd0;
          if (!is_rd) begin
            ss_nx    = 1'b1;
            state_nx = DONE;
          end else if (RD_GAP == 0) begin
            state_nx = RX;
          end else begin
            state_nx = GAP;
          end
        end else begin
          mosi_nx  = tx_sh[9];
          tx_sh_nx = {tx_sh[8:0], 1'b0};
          cnt_nx   = cnt + 4'd1;
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = 4'd0;
          state_nx = RX;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end

      RX: begin
        rx_sh_nx = {rx_sh[5:0], bus.MISO};
        if (cnt == RX_LAST) begin
          rsp_data_nx  = {rx_sh, bus.MISO};
          rsp_valid_nx = 1'b1;
          ss_nx        = 1'b1;
          mosi_nx      = 1'b0;
          cnt_nx       = 4'd0;
          state_nx     = DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end

      DONE: begin
        ss_nx    = 1'b1;
        mosi_nx  = 1'b0;
        cnt_nx   = 4'd0;
        state_nx = IDLE;
      end

      default: begin
        ss_nx    = 1'b1;
        mosi_nx  = 1'b0;
        cnt_nx   = 4'd0;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state == IDLE) && rst_n;
  assign bus.busy      = (state != IDLE);
  assign bus.MOSI      = mosi_q;
  assign bus.SS_n      = ss_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (LEAD=1/GAP=1 and LEAD=3/GAP=0), each with a serial RAM slave model.
// A frame-level expectation model is compared against every output on every cycle after reset.
// Directed scenarios add hand-computed checks on frame length, bit order, latency and returned bytes.
module tb_spi_ram_master;
  localparam int L0 = 1;
  localparam int G0 = 1;
  localparam int L1 = 3;
  localparam int G1 = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_ram_master_if bus0 ();
  spi_ram_master_if bus1 ();

  spi_ram_master #(.LEAD_CYCLES(L0), .RD_GAP(G0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  spi_ram_master #(.LEAD_CYCLES(L1), .RD_GAP(G1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  // Per-instance views of the bus so the checking code can be indexed.
  logic       cv   [2];
  logic [1:0] cop  [2];
  logic [7:0] cpl  [2];
  logic       miso [2];
  logic       rdy  [2];
  logic       rv   [2];
  logic       bsy  [2];
  logic       mo   [2];
  logic       ss   [2];
  logic [7:0] rdat [2];

  assign bus0.cmd_valid = cv[0];   assign bus1.cmd_valid = cv[1];
  assign bus0.cmd_op = cop[0];     assign bus1.cmd_op = cop[1];
  assign bus0.cmd_payload = cpl[0]; assign bus1.cmd_payload = cpl[1];
  assign bus0.MISO = miso[0];      assign bus1.MISO = miso[1];
  assign rdy[0] = bus0.cmd_ready;  assign rdy[1] = bus1.cmd_ready;
  assign rv[0] = bus0.rsp_valid;   assign rv[1] = bus1.rsp_valid;
  assign bsy[0] = bus0.busy;       assign bsy[1] = bus1.busy;
  assign mo[0] = bus0.MOSI;        assign mo[1] = bus1.MOSI;
  assign ss[0] = bus0.SS_n;        assign ss[1] = bus1.SS_n;
  assign rdat[0] = bus0.rsp_data;  assign rdat[1] = bus1.rsp_data;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  // Serial RAM slave model state.
  logic [7:0] sram [2][256];
  int         scnt [2] = '{0, 0};
  logic [9:0] sframe [2];
  logic [7:0] swaddr [2] = '{8'h00, 8'h00};
  logic [7:0] sraddr [2] = '{8'h00, 8'h00};
  logic [7:0] srbyte [2] = '{8'h00, 8'h00};

  // Expectation model state: t = cycles since the accept cycle (0 = idle), n = SS_n-low length of the frame.
  logic [7:0] mram [2][256];
  int         mt [2] = '{0, 0};
  int         mn [2] = '{0, 0};
  logic [9:0] mframe [2] = '{10'd0, 10'd0};
  logic [7:0] mrsp [2] = '{8'h00, 8'h00};
  logic [7:0] mwaddr [2] = '{8'h00, 8'h00};
  logic [7:0] mraddr [2] = '{8'h00, 8'h00};

  // Observations used by the directed checks.
  int          cyc [2] = '{0, 0};
  int          low_run [2] = '{0, 0};
  int          high_run [2] = '{0, 0};
  int          last_low [2] = '{0, 0};
  int          last_gap [2] = '{0, 0};
  int          frames [2] = '{0, 0};
  int          acc_cnt [2] = '{0, 0};
  int          acc_cyc [2] = '{0, 0};
  int          rsp_cnt [2] = '{0, 0};
  int          rsp_cyc [2] = '{0, 0};
  logic [7:0]  rsp_last [2] = '{8'h00, 8'h00};
  logic        prev_ss [2] = '{1'b1, 1'b1};
  logic [31:0] mosi_sh [2] = '{32'd0, 32'd0};

  function automatic int lead_of(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: counts SS_n-low cycles, decodes the frame, and drives the reply for the RX window (noise elsewhere).
  task automatic slave_step(input int d);
    int k, l, g;
    l = lead_of(d);
    g = gap_of(d);
    if (ss[d] !== 1'b0) begin
      scnt[d] = 0;
      miso[d] = 1'($urandom);
    end else begin
      scnt[d] = scnt[d] + 1;
      k = scnt[d];
      if (k > l && k <= l + 10) sframe[d] = {sframe[d][8:0], mo[d]};
      if (k == l + 10) begin
        case (sframe[d][9:8])
          2'b00:   swaddr[d] = sframe[d][7:0];
          2'b01:   sram[d][swaddr[d]] = sframe[d][7:0];
          2'b10:   sraddr[d] = sframe[d][7:0];
          default: srbyte[d] = sram[d][sraddr[d]];
        endcase
      end
      if (k > l + 10 + g && k <= l + 18 + g) miso[d] = srbyte[d][7 - (k - l - 11 - g)];
      else miso[d] = 1'($urandom);
    end
  endtask

  // Model: expected pin/handshake values from the frame offset, then advance by this cycle's inputs.
  task automatic model_step(input int d);
    int l, g, t, n;
    logic e_mosi;
    logic [1:0] op;
    l = lead_of(d);
    g = gap_of(d);
    t = mt[d];
    n = mn[d];
    op = mframe[d][9:8];
    e_mosi = 1'b0;
    if (t > l && t <= l + 10) e_mosi = mframe[d][9 - (t - l - 1)];
    check($sformatf("dut%0d_ss_n", d), 32'(ss[d]), 32'(!(t >= 1 && t <= n)));
    check($sformatf("dut%0d_mosi", d), 32'(mo[d]), 32'(e_mosi));
    check($sformatf("dut%0d_busy", d), 32'(bsy[d]), 32'(t != 0));
    check($sformatf("dut%0d_cmd_ready", d), 32'(rdy[d]), 32'(t == 0 && rst_n == 1'b1));
    check($sformatf("dut%0d_rsp_valid", d), 32'(rv[d]), 32'(t != 0 && t == n + 1 && op == 2'b11));
    check($sformatf("dut%0d_rsp_data", d), 32'(rdat[d]), 32'(mrsp[d]));
    if (rst_n !== 1'b1) begin
      mt[d] = 0;
      mrsp[d] = 8'h00;
    end else if (t == 0) begin
      if (cv[d] === 1'b1) begin
        mframe[d] = {cop[d], cpl[d]};
        mn[d] = l + 10 + ((cop[d] == 2'b11) ? g + 8 : 0);
        mt[d] = 1;
      end
    end else if (t == n + 1) begin
      mt[d] = 0;
    end else begin
      mt[d] = t + 1;
      if (t == n) begin
        case (op)
          2'b00:   mwaddr[d] = mframe[d][7:0];
          2'b01:   mram[d][mwaddr[d]] = mframe[d][7:0];
          2'b10:   mraddr[d] = mframe[d][7:0];
          default: mrsp[d] = mram[d][mraddr[d]];
        endcase
      end
    end
  endtask

  task automatic monitor_step(input int d);
    cyc[d] = cyc[d] + 1;
    if (ss[d] == 1'b0) begin
      if (prev_ss[d]) begin
        frames[d] = frames[d] + 1;
        last_gap[d] = high_run[d];
        low_run[d] = 0;
      end
      low_run[d] = low_run[d] + 1;
      mosi_sh[d] = {mosi_sh[d][30:0], mo[d]};
    end else begin
      if (!prev_ss[d]) begin
        last_low[d] = low_run[d];
        high_run[d] = 0;
      end
      high_run[d] = high_run[d] + 1;
    end
    prev_ss[d] = ss[d];
    if (cv[d] && rdy[d]) begin
      acc_cnt[d] = acc_cnt[d] + 1;
      acc_cyc[d] = cyc[d];
    end
    if (rv[d]) begin
      rsp_cnt[d] = rsp_cnt[d] + 1;
      rsp_cyc[d] = cyc[d];
      rsp_last[d] = rdat[d];
    end
  endtask

  // Single compare process: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        model_step(d);
        monitor_step(d);
        slave_step(d);
      end
    end
  end

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy[d] !== 1'b1 && n < 100) begin
      n = n + 1;
      @(negedge clk);
    end
    if (rdy[d] !== 1'b1) check($sformatf("dut%0d_accept_timeout", d), 32'(rdy[d]), 32'd1);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (bsy[d] !== 1'b0 && n < 200) begin
      n = n + 1;
      @(negedge clk);
    end
    if (bsy[d] !== 1'b0) check($sformatf("dut%0d_idle_timeout", d), 32'(bsy[d]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Offer one command, hold it until accepted, then scramble the bus and wait for the frame to finish.
  task automatic send(input int d, input logic [1:0] op, input logic [7:0] pl);
    cv[d] = 1'b1;
    cop[d] = op;
    cpl[d] = pl;
    wait_ready(d);
    @(posedge clk);
    #1;
    cv[d] = 1'b0;
    cop[d] = 2'($urandom);
    cpl[d] = 8'($urandom);
    wait_idle(d);
  endtask

  initial begin
    int a0, f0, r0, first_acc;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0;
      cop[d] = 2'b00;
      cpl[d] = 8'h00;
      miso[d] = 1'b0;
      for (int a = 0; a < 256; a++) begin
        sram[d][a] = 8'h00;
        mram[d][a] = 8'h00;
      end
    end
    sram[0][8'h10] = 8'hA5; mram[0][8'h10] = 8'hA5;
    sram[0][8'h20] = 8'hC3; mram[0][8'h20] = 8'hC3;
    sram[1][8'h30] = 8'hFF; mram[1][8'h30] = 8'hFF;
    sram[1][8'h31] = 8'h00; mram[1][8'h31] = 8'h00;

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write-addr 0x3C: 11 low cycles, lead bit then 00_00111100.
    send(0, 2'b00, 8'h3C);
    check("wa_ss_low_len", 32'(last_low[0]), 32'd11);
    check("wa_mosi_bits", 32'(mosi_sh[0][10:0]), 32'h03C);
    check("wa_no_rsp", 32'(rsp_cnt[0]), 32'd0);

    // Read-data returning 0xA5.
    send(0, 2'b10, 8'h10);
    send(0, 2'b11, 8'h00);
    check("rd_rsp_count", 32'(rsp_cnt[0]), 32'd1);
    check("rd_latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd21);
    check("rd_data", 32'(rsp_last[0]), 32'hA5);
    check("rd_ss_low_len", 32'(last_low[0]), 32'd20);

    // Full loop: write 0x5A to 0x3C and read it back.
    send(0, 2'b00, 8'h3C);
    send(0, 2'b01, 8'h5A);
    check("loop_rsp_data_kept", 32'(rdat[0]), 32'hA5);
    send(0, 2'b10, 8'h3C);
    send(0, 2'b11, 8'hE7);
    check("loop_rd_data", 32'(rsp_last[0]), 32'h5A);
    check("loop_rsp_count", 32'(rsp_cnt[0]), 32'd2);

    // Back-to-back write-data with cmd_valid held high throughout.
    a0 = acc_cnt[0];
    f0 = frames[0];
    cv[0] = 1'b1;
    cop[0] = 2'b01;
    cpl[0] = 8'h11;
    wait_ready(0);
    @(posedge clk);
    #1;
    cpl[0] = 8'h22;
    first_acc = acc_cyc[0];
    wait_ready(0);
    @(posedge clk);
    #1;
    cv[0] = 1'b0;
    wait_idle(0);
    check("b2b_accept_spacing", 32'(acc_cyc[0] - first_acc), 32'd13);
    check("b2b_ss_high_gap", 32'(last_gap[0]), 32'd2);
    check("b2b_accepts", 32'(acc_cnt[0] - a0), 32'd2);
    check("b2b_frames", 32'(frames[0] - f0), 32'd2);

    // Reset during RX bit 4 of a read, then a clean read of 0xC3.
    send(0, 2'b10, 8'h10);
    cv[0] = 1'b1;
    cop[0] = 2'b11;
    cpl[0] = 8'h00;
    wait_ready(0);
    @(posedge clk);
    #1;
    cv[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    r0 = rsp_cnt[0];
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ss_n", 32'(ss[0]), 32'd1);
    check("rst_mosi", 32'(mo[0]), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_rsp_data", 32'(rdat[0]), 32'h00);
    check("rst_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);
    @(posedge clk);
    #1;
    send(0, 2'b10, 8'h20);
    send(0, 2'b11, 8'h00);
    check("post_rst_rd_data", 32'(rsp_last[0]), 32'hC3);
    check("post_rst_rsp_count", 32'(rsp_cnt[0] - r0), 32'd1);

    // LEAD=3, RD_GAP=0 instance: reads 0xFF then 0x00.
    send(1, 2'b10, 8'h30);
    send(1, 2'b11, 8'h00);
    check("p_rd_ff", 32'(rsp_last[1]), 32'hFF);
    check("p_ss_low_len", 32'(last_low[1]), 32'd21);
    check("p_latency", 32'(rsp_cyc[1] - acc_cyc[1]), 32'd22);
    send(1, 2'b10, 8'h31);
    send(1, 2'b11, 8'h00);
    check("p_rd_00", 32'(rsp_last[1]), 32'h00);
    check("p_rsp_count", 32'(rsp_cnt[1]), 32'd2);

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- Host-side SPI master that drives the serial RAM slave subsystem: MOSI, SS_n, MISO, sharing its clk as SCK.
- Accepts 2-bit-opcode + 8-bit-payload commands over a valid/ready handshake.
- Serializes each command as a 10-bit frame, MSB first.
- For read-data commands, deserializes the 8-bit reply from MISO and returns it on a one-cycle response strobe.

Parameters:
- LEAD_CYCLES, 1, cycles SS_n is held low with MOSI=0 before the first command bit (range 1..7).
- RD_GAP, 1, cycles between the last command bit and the first sampled MISO bit on read-data frames (range 0..7).

Ports:
- clk  input  1  system clock; also the SPI bit clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  master can accept a command this cycle.
- cmd_op  input  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_payload  input  8  address or data byte; don't-care content is still shifted for op 11.
- rsp_valid  output  1  one-cycle pulse when rsp_data is updated.
- rsp_data  output  8  byte read from slave; holds until next read completes.
- busy  output  1  high whenever state != IDLE.
- MOSI  output  1  serial data to slave; registered.
- SS_n  output  1  slave select, active low; registered.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset, on the edge with rst_n=0:
  - SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0x00, state=IDLE, all counters 0.
  - cmd_ready is forced 0 while rst_n=0.
- States: IDLE, LEAD, TX, GAP, RX, DONE.
- IDLE:
  - cmd_ready=1, SS_n=1, MOSI=0.
  - On a cycle with cmd_valid & cmd_ready, latch {cmd_op, cmd_payload} into a 10-bit shift register, set SS_n<=0, go to LEAD.
- LEAD:
  - SS_n=0, MOSI=0 for LEAD_CYCLES cycles.
  - On the edge leaving LEAD, MOSI<=bit9.
- TX:
  - 10 cycles; MOSI presents bit9..bit0, one bit per cycle, each bit stable for exactly one clk period.
  - After bit0: op==11 goes to GAP (or directly to RX if RD_GAP=0); otherwise goes to DONE.
- GAP:
  - SS_n=0, MOSI=0 for RD_GAP cycles.
- RX:
  - 8 cycles; MISO sampled on each rising edge and shifted in MSB first.
- DONE:
  - Entered with SS_n<=1, MOSI<=0; lasts 1 cycle, then IDLE.
  - For read-data frames, rsp_data<=captured byte and rsp_valid=1 during the DONE cycle only.
- Frame timing:
  - SS_n low for LEAD_CYCLES+10 cycles (ops 00/01/10), or LEAD_CYCLES+10+RD_GAP+8 cycles (op 11).
  - SS_n is high for at least 2 cycles between back-to-back frames (DONE + IDLE accept cycle).
  - Command accept to rsp_valid (op 11) is LEAD_CYCLES+10+RD_GAP+8+1 cycles.
- Handshake:
  - cmd_valid while busy is ignored and nothing is latched; the host must hold cmd_valid until it sees cmd_ready.
  - cmd_op/cmd_payload may change freely after acceptance.
- Ops 00/01/10 never assert rsp_valid and never modify rsp_data.
- MISO is ignored outside RX.
- Reset mid-frame: the next edge with rst_n=0 aborts. SS_n=1, no rsp_valid, rsp_data cleared to 0x00, and the partial frame is discarded.
- Counters are sized for the parameter ranges and never wrap within a frame.

Test Plan:
- Write-addr: op=00, payload=0x3C, LEAD=1 -> SS_n low 11 cycles; MOSI after the lead cycle = 0,0,0,0,1,1,1,1,0,0; no rsp_valid.
- Read-data with a MISO driver model: op=11 and the model returns 0xA5 starting RD_GAP cycles after the last command bit -> rsp_valid pulses once, 1+10+1+8+1=21 cycles after acceptance, with rsp_data=0xA5; SS_n low exactly 20 cycles.
- Full loop against the slave/RAM wrapper: write-addr 0x3C, write-data 0x5A, read-addr 0x3C, read-data -> rsp_data=0x5A.
- Back-to-back: cmd_valid held high across two write-data commands (0x11, 0x22) -> second accepted in the first IDLE cycle; SS_n high exactly 2 cycles between frames; cmd_valid during busy is not accepted.
- Reset mid-read: assert rst_n=0 during RX bit 4 -> next edge SS_n=1, MOSI=0, busy=0, rsp_data=0x00, no rsp_valid; a following read of 0xC3 completes normally.
- Parameter sweep: LEAD_CYCLES=3, RD_GAP=0, read returning 0xFF then 0x00 -> SS_n low 21 cycles; correct bytes returned.
